// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e : FSM state encoding (idle / shifting / result-ready)
//   clog2   : constant function sizing the bit counter
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Ceiling log2, used at elaboration time only; returns at least 1 so a
    // counter built from it always has a legal width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
//   master : drives start, a, b; observes diff, borrow_out, busy, done
//   slave  : the subtractor side of the same signals
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  diff, borrow_out, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow_out, busy, done
    );

endinterface

// File: rtl/half_subtractor.sv
// Combinational half subtractor: one-bit a - b.
//   a_i, b_i  : operand bits
//   diff_o    : a ^ b
//   borrow_o  : 1 when a=0 and b=1
module half_subtractor (
    input  logic a_i,
    input  logic b_i,
    output logic diff_o,
    output logic borrow_o
);

    assign diff_o   = a_i ^ b_i;
    assign borrow_o = ~a_i & b_i;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave modport carrying start/a/b in and diff/borrow_out/busy/done out
// Operands are captured when start is seen in idle; WIDTH shift cycles later
// the result and final borrow (a < b unsigned) are registered and done pulses
// for one cycle, after which the block returns to idle.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int unsigned      CntW   = clog2(WIDTH);
    localparam logic [CntW-1:0]  CntMax = CntW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               br_q, br_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;

    // Full subtractor from two half subtractors: first a-b, then minus the
    // incoming borrow; either stage borrowing produces the outgoing borrow.
    logic hs1_diff, hs1_borrow;
    logic bit_d, hs2_borrow;
    logic br_next;

    half_subtractor u_hs_ab (
        .a_i      (a_q[0]),
        .b_i      (b_q[0]),
        .diff_o   (hs1_diff),
        .borrow_o (hs1_borrow)
    );

    half_subtractor u_hs_br (
        .a_i      (hs1_diff),
        .b_i      (br_q),
        .diff_o   (bit_d),
        .borrow_o (hs2_borrow)
    );

    assign br_next = hs1_borrow | hs2_borrow;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        dsr_d    = dsr_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // New result bit enters at the MSB so the LSB-first stream
                // ends up in place after WIDTH shifts.
                dsr_d = (dsr_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
                br_d  = br_next;
                if (cnt_q == CntMax) begin
                    diff_d   = dsr_d;
                    borrow_d = br_next;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            dsr_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dsr_q    <= dsr_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);

endmodule
